stamp_sync_ctrl: RTL and testbench
==================================

Name: stamp_sync_ctrl

Overview:
Control stage directly upstream of the timestamp counter. It generates that counter's `restart_time[1:0]` command pulses and `ntp_timestamp` load value.
- Host-initiated loads are either immediate or aligned to the next rising edge of an external asynchronous PPS input.
- The PPS input is synchronised, edge-detected and counted.
- A sticky error is raised when an armed PPS load times out.

Parameters:
- TIMESTAMP_WIDTH, 64, width of host_time and ntp_timestamp.
- SYNC_STAGES, 2, flops in the pps_in synchroniser (minimum 2).
- PPS_TIMEOUT, 200000000, cycles ARMED may wait for a PPS edge before aborting (minimum 2).

Ports:
- axi_aclk  in  1  clock.
- axi_reset  in  1  synchronous reset, active-high.
- sw_clear  in  1  one-cycle request: zero the downstream counter.
- sw_load_time  in  1  one-cycle request: load host_time immediately.
- sw_arm_pps  in  1  one-cycle request: load host_time at the next PPS rising edge.
- host_time  in  TIMESTAMP_WIDTH  time value sampled when a request is accepted.
- pps_in  in  1  asynchronous PPS pulse.
- restart_time  out  2  bit0 = load ntp_timestamp, bit1 = clear; both registered.
- ntp_timestamp  out  TIMESTAMP_WIDTH  load value; holds the last loaded value.
- armed  out  1  high while in ARMED.
- pps_count  out  32  count of synchronised PPS rising edges.
- timeout_err  out  1  sticky armed-load timeout flag.

Behaviour:
- Reset: all outputs 0, internal armed_time 0, timeout counter 0, synchroniser flops 0, FSM in IDLE.
- PPS path:
  - pps_in passes through SYNC_STAGES flops, then a one-flop edge detect.
  - pps_rise is a one-cycle pulse, asserted SYNC_STAGES+1 cycles after pps_in rises.
- pps_count increments on every pps_rise in any state and wraps 0xFFFFFFFF -> 0.
- Request priority when several arrive in one cycle: sw_clear > sw_load_time > sw_arm_pps. Lower-priority requests in that cycle are dropped.
- FSM states: IDLE (armed=0), ARMED (armed=1).
- IDLE transitions:
  - sw_clear: restart_time=2'b10 next cycle; stay IDLE.
  - sw_load_time: ntp_timestamp<=host_time and restart_time=2'b01, both next cycle; stay IDLE.
  - sw_arm_pps: armed_time<=host_time, timeout counter<=0, timeout_err<=0; go to ARMED.
  - pps_rise while IDLE: counted only, no load.
- ARMED transitions:
  - pps_rise: ntp_timestamp<=armed_time, restart_time=2'b01 next cycle; go to IDLE.
  - No pps_rise: timeout counter +1 each cycle. When counter == PPS_TIMEOUT-1: timeout_err<=1, go to IDLE, no pulse.
  - pps_rise and timeout in the same cycle: pps_rise wins and timeout_err stays 0.
  - sw_clear: abort the arm, issue the clear pulse, go to IDLE.
  - sw_load_time: abort the arm, perform the immediate load, go to IDLE.
  - sw_arm_pps: re-latch armed_time from host_time, reset the timeout counter, stay ARMED.
  - Any request in the same cycle as pps_rise: the request wins; the PPS edge is only counted.
- Pulse rules:
  - restart_time is all-zero except for exactly one cycle per accepted action.
  - It is never 2'b11.
  - Back-to-back requests give back-to-back pulses.
- ntp_timestamp changes only in the cycle its restart_time[0] pulse is asserted.
- timeout_err clears only on reset or on an accepted sw_arm_pps.
- Reset during ARMED: returns to IDLE with no pulse; the pending load is discarded.
- Arithmetic: all timestamp arithmetic is modulo 2^TIMESTAMP_WIDTH.

Optional Feature:
- Macro STAMP_SYNC_PPS_COMPENSATE_EN.
- When defined: a PPS-aligned load uses ntp_timestamp<=armed_time+(SYNC_STAGES+2). This compensates the synchroniser, edge-detect and load latency so the downstream counter reads armed_time+k, k cycles after the true pps_in edge.
- Immediate loads (sw_load_time) are never compensated.
- When undefined: PPS-aligned loads use armed_time unmodified.

Test Plan:
- Reset: hold axi_reset 3 cycles, then release -> restart_time=0, ntp_timestamp=0, armed=0, pps_count=0, timeout_err=0.
- Immediate load: sw_load_time with host_time=64'h0000_0001_2345_6789 at cycle N -> at N+1 restart_time=2'b01 for one cycle and ntp_timestamp=64'h0000_0001_2345_6789; at N+2 restart_time=0.
- PPS load: sw_arm_pps with host_time=64'hA0, then pps_in high 10 cycles later (SYNC_STAGES=2):
  - pps_rise 3 cycles after the edge.
  - restart_time=2'b01 the next cycle.
  - ntp_timestamp=64'hA0 (64'hA4 with the macro).
  - armed returns to 0; pps_count=1.
- Timeout: PPS_TIMEOUT=100, sw_arm_pps, no PPS -> armed drops and timeout_err=1 exactly 100 cycles after arming, with no restart pulse. A following sw_arm_pps clears timeout_err.
- Priority: sw_clear, sw_load_time and sw_arm_pps in one cycle while ARMED -> single restart_time=2'b10 pulse, ntp_timestamp unchanged, armed=0.
- Collision: sw_load_time (host_time=64'h55) in the same cycle as pps_rise while ARMED (armed_time=64'hA0) -> ntp_timestamp=64'h55, one 2'b01 pulse, pps_count+1.

Source files
------------

// File: rtl/stamp_sync_ctrl.sv
// stamp_sync_ctrl: command/load-value generator for the downstream timestamp counter.
// Host requests either load host_time immediately or arm a load that fires on the
// next synchronised PPS rising edge. An armed load that sees no PPS edge within
// PPS_TIMEOUT cycles is abandoned and raises a sticky timeout_err.
// Optional feature macro: STAMP_SYNC_PPS_COMPENSATE_EN -- when defined, PPS-aligned
// loads add the synchroniser/edge-detect/load latency (SYNC_STAGES+2) to armed_time.
module stamp_sync_ctrl #(
    parameter int unsigned TIMESTAMP_WIDTH = 64,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned PPS_TIMEOUT     = 200000000
) (
    input  logic                       axi_aclk,
    input  logic                       axi_reset,
    input  logic                       sw_clear,
    input  logic                       sw_load_time,
    input  logic                       sw_arm_pps,
    input  logic [TIMESTAMP_WIDTH-1:0] host_time,
    input  logic                       pps_in,
    output logic [1:0]                 restart_time,
    output logic [TIMESTAMP_WIDTH-1:0] ntp_timestamp,
    output logic                       armed,
    output logic [31:0]                pps_count,
    output logic                       timeout_err
);

    localparam int unsigned TS_W  = TIMESTAMP_WIDTH;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned TO_W  = $clog2(PPS_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(PPS_TIMEOUT - 1);

`ifdef STAMP_SYNC_PPS_COMPENSATE_EN
    localparam logic [TS_W-1:0] PPS_ADJ = TS_W'(SYNC_STAGES + 2);
`else
    localparam logic [TS_W-1:0] PPS_ADJ = '0;
`endif

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    pps_prev_q;
    logic                    pps_rise_q;
    logic [1:0]              restart_q, restart_d;
    logic [TS_W-1:0]         ntp_q, ntp_d;
    logic [TS_W-1:0]         armed_time_q, armed_time_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        pps_cnt_q, pps_cnt_d;
    logic                    pps_sync_c;

    assign pps_sync_c = sync_q[SYNC_STAGES-1];

    // PPS synchroniser chain followed by a registered rising-edge detect
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            sync_q     <= '0;
            pps_prev_q <= 1'b0;
            pps_rise_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pps_in};
            pps_prev_q <= pps_sync_c;
            pps_rise_q <= pps_sync_c & ~pps_prev_q;
        end
    end

    // FSM state and all registered outputs
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q      <= IDLE;
            restart_q    <= CMD_NONE;
            ntp_q        <= '0;
            armed_time_q <= '0;
            to_cnt_q     <= '0;
            err_q        <= 1'b0;
            pps_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            restart_q    <= restart_d;
            ntp_q        <= ntp_d;
            armed_time_q <= armed_time_d;
            to_cnt_q     <= to_cnt_d;
            err_q        <= err_d;
            pps_cnt_q    <= pps_cnt_d;
        end
    end

    // Next-state logic: requests by priority clear > load > arm, then PPS, then timeout
    always_comb begin
        state_d      = state_q;
        restart_d    = CMD_NONE;
        ntp_d        = ntp_q;
        armed_time_d = armed_time_q;
        to_cnt_d     = to_cnt_q;
        err_d        = err_q;
        pps_cnt_d    = pps_rise_q ? pps_cnt_q + CNT_W'(1) : pps_cnt_q;

        case (state_q)
            IDLE: begin
                if (sw_clear) begin
                    restart_d = CMD_CLEAR;
                end else if (sw_load_time) begin
                    ntp_d     = host_time;
                    restart_d = CMD_LOAD;
                end else if (sw_arm_pps) begin
                    armed_time_d = host_time;
                    to_cnt_d     = '0;
                    err_d        = 1'b0;
                    state_d      = ARMED;
                end
            end
            ARMED: begin
                if (sw_clear) begin
                    restart_d = CMD_CLEAR;
                    state_d   = IDLE;
                end else if (sw_load_time) begin
                    ntp_d     = host_time;
                    restart_d = CMD_LOAD;
                    state_d   = IDLE;
                end else if (sw_arm_pps) begin
                    armed_time_d = host_time;
                    to_cnt_d     = '0;
                    err_d        = 1'b0;
                end else if (pps_rise_q) begin
                    ntp_d     = armed_time_q + PPS_ADJ;
                    restart_d = CMD_LOAD;
                    state_d   = IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign restart_time  = restart_q;
    assign ntp_timestamp = ntp_q;
    assign armed         = (state_q == ARMED);
    assign pps_count     = pps_cnt_q;
    assign timeout_err   = err_q;

endmodule

// File: tb/tb_stamp_sync_ctrl.sv
// Directed self-checking bench for stamp_sync_ctrl (SYNC_STAGES=2, PPS_TIMEOUT=100).
module tb_stamp_sync_ctrl;

    localparam int unsigned TW = 64;

`ifdef STAMP_SYNC_PPS_COMPENSATE_EN
    localparam logic [TW-1:0] PPS_EXP = 64'hA4;
`else
    localparam logic [TW-1:0] PPS_EXP = 64'hA0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          sw_clear;
    logic          sw_load_time;
    logic          sw_arm_pps;
    logic [TW-1:0] host_time;
    logic          pps_in;
    logic [1:0]    restart_time;
    logic [TW-1:0] ntp_timestamp;
    logic          armed;
    logic [31:0]   pps_count;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;
    int bad_pulses;

    stamp_sync_ctrl #(
        .TIMESTAMP_WIDTH(TW),
        .SYNC_STAGES    (2),
        .PPS_TIMEOUT    (100)
    ) dut (
        .axi_aclk     (clk),
        .axi_reset    (rst),
        .sw_clear     (sw_clear),
        .sw_load_time (sw_load_time),
        .sw_arm_pps   (sw_arm_pps),
        .host_time    (host_time),
        .pps_in       (pps_in),
        .restart_time (restart_time),
        .ntp_timestamp(ntp_timestamp),
        .armed        (armed),
        .pps_count    (pps_count),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_req();
        sw_clear     = 1'b0;
        sw_load_time = 1'b0;
        sw_arm_pps   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_req();
        host_time = '0;
        pps_in    = 1'b0;

        // Reset
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_restart", 64'(restart_time), 64'd0);
        chk("rst_ntp", ntp_timestamp, 64'd0);
        chk("rst_armed", 64'(armed), 64'd0);
        chk("rst_pps_count", 64'(pps_count), 64'd0);
        chk("rst_err", 64'(timeout_err), 64'd0);

        // Immediate load
        host_time    = 64'h0000_0001_2345_6789;
        sw_load_time = 1'b1;
        step();
        idle_req();
        chk("imm_pulse", 64'(restart_time), 64'd1);
        chk("imm_ntp", ntp_timestamp, 64'h0000_0001_2345_6789);
        step();
        chk("imm_pulse_end", 64'(restart_time), 64'd0);
        chk("imm_ntp_hold", ntp_timestamp, 64'h0000_0001_2345_6789);

        // Back-to-back clear then load
        sw_clear = 1'b1;
        step();
        idle_req();
        chk("b2b_clear", 64'(restart_time), 64'd2);
        chk("b2b_clear_ntp", ntp_timestamp, 64'h0000_0001_2345_6789);
        host_time    = 64'h99;
        sw_load_time = 1'b1;
        step();
        idle_req();
        chk("b2b_load", 64'(restart_time), 64'd1);
        chk("b2b_load_ntp", ntp_timestamp, 64'h99);
        step();
        chk("b2b_end", 64'(restart_time), 64'd0);

        // PPS-aligned load
        host_time  = 64'hA0;
        sw_arm_pps = 1'b1;
        step();
        idle_req();
        host_time = 64'h1234;
        chk("pps_armed", 64'(armed), 64'd1);
        repeat (9) step();
        pps_in = 1'b1;
        step();
        step();
        step();
        chk("pps_wait_pulse", 64'(restart_time), 64'd0);
        chk("pps_wait_armed", 64'(armed), 64'd1);
        chk("pps_wait_count", 64'(pps_count), 64'd0);
        step();
        chk("pps_pulse", 64'(restart_time), 64'd1);
        chk("pps_ntp", ntp_timestamp, PPS_EXP);
        chk("pps_disarm", 64'(armed), 64'd0);
        chk("pps_count1", 64'(pps_count), 64'd1);
        step();
        chk("pps_pulse_end", 64'(restart_time), 64'd0);
        pps_in = 1'b0;
        repeat (5) step();
        chk("pps_no_extra", 64'(pps_count), 64'd1);

        // Timeout
        host_time  = 64'h77;
        sw_arm_pps = 1'b1;
        step();
        idle_req();
        chk("to_armed", 64'(armed), 64'd1);
        bad_pulses = 0;
        for (int i = 0; i < 99; i++) begin
            step();
            if (restart_time != 2'b00) bad_pulses++;
        end
        chk("to_still_armed", 64'(armed), 64'd1);
        chk("to_no_err_yet", 64'(timeout_err), 64'd0);
        step();
        if (restart_time != 2'b00) bad_pulses++;
        chk("to_disarm", 64'(armed), 64'd0);
        chk("to_err", 64'(timeout_err), 64'd1);
        chk("to_no_pulse", 64'(bad_pulses), 64'd0);
        chk("to_ntp_hold", ntp_timestamp, PPS_EXP);
        step();
        chk("to_err_sticky", 64'(timeout_err), 64'd1);
        host_time  = 64'hB0;
        sw_arm_pps = 1'b1;
        step();
        idle_req();
        chk("rearm_err_clr", 64'(timeout_err), 64'd0);
        chk("rearm_armed", 64'(armed), 64'd1);

        // Priority: all requests at once while armed
        host_time    = 64'hDEAD;
        sw_clear     = 1'b1;
        sw_load_time = 1'b1;
        sw_arm_pps   = 1'b1;
        step();
        idle_req();
        chk("prio_pulse", 64'(restart_time), 64'd2);
        chk("prio_ntp", ntp_timestamp, PPS_EXP);
        chk("prio_armed", 64'(armed), 64'd0);
        step();
        chk("prio_pulse_end", 64'(restart_time), 64'd0);

        // Collision: immediate load in the same cycle as pps_rise while armed
        host_time  = 64'hA0;
        sw_arm_pps = 1'b1;
        step();
        idle_req();
        chk("col_armed", 64'(armed), 64'd1);
        pps_in = 1'b1;
        step();
        step();
        step();
        host_time    = 64'h55;
        sw_load_time = 1'b1;
        step();
        idle_req();
        chk("col_pulse", 64'(restart_time), 64'd1);
        chk("col_ntp", ntp_timestamp, 64'h55);
        chk("col_armed_off", 64'(armed), 64'd0);
        chk("col_count", 64'(pps_count), 64'd2);
        bad_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (restart_time != 2'b00) bad_pulses++;
        end
        chk("col_no_late_pulse", 64'(bad_pulses), 64'd0);
        chk("col_ntp_hold", ntp_timestamp, 64'h55);

        // Reset while armed discards the pending load
        pps_in     = 1'b0;
        repeat (3) step();
        host_time  = 64'hC0;
        sw_arm_pps = 1'b1;
        step();
        idle_req();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstarm_armed", 64'(armed), 64'd0);
        chk("rstarm_ntp", ntp_timestamp, 64'd0);
        pps_in = 1'b1;
        repeat (6) step();
        chk("rstarm_no_load", ntp_timestamp, 64'd0);
        chk("rstarm_count", 64'(pps_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
